// File: rtl/io_bank_cfg_pkg.sv
// Shared constants and types for the io bank configuration chain.
// Bit positions inside each pad's config slice, plus the chain fill phase.
package io_bank_cfg_pkg;

  localparam int CFG_DIR     = 0;
  localparam int CFG_INV_IN  = 1;
  localparam int CFG_INV_OUT = 2;
  localparam int CFG_MIN_BITS = 3;

  typedef enum logic [1:0] {
    PH_EMPTY,
    PH_SHIFTING,
    PH_FULL
  } cfg_phase_t;

  function automatic cfg_phase_t phase_of(
    input int cnt,
    input int total
  );
    cfg_phase_t ph;
    ph = PH_SHIFTING;
    if (cnt == 0) ph = PH_EMPTY;
    if (cnt >= total) ph = PH_FULL;
    return ph;
  endfunction

endpackage

// File: rtl/io_bank_cfg_chain.sv
// Double-buffered config chain: shadow shift register, active copy,
// frame counter and status flags, all clocked by prog_clk.
module io_bank_cfg_chain
  import io_bank_cfg_pkg::*;
#(
  parameter int TOTAL = 12,
  parameter int CNT_W = $clog2(TOTAL + 1)
) (
  input  logic             prog_clk,
  input  logic             pReset,
  input  logic             shift_en,
  input  logic             head,
  input  logic             load,
  output logic             tail,
  output logic [TOTAL-1:0] active,
  output logic             cfg_valid,
  output logic             cfg_full,
  output logic             cfg_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TOTAL);

  logic [TOTAL-1:0] shadow_q, shadow_d;
  logic [TOTAL-1:0] active_q, active_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  cfg_phase_t       phase_q, phase_d;
  logic             full;

  assign full = (count_q == CNT_MAX);

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    count_d  = count_q;
    valid_d  = valid_q;
    err_d    = err_q;
    if (shift_en) begin
      shadow_d = {head, shadow_q[TOTAL-1:1]};
    end
    // A good load captures the pre-edge shadow even if a shift happens too
    if (load && full) begin
      active_d = shadow_q;
      valid_d  = 1'b1;
      count_d  = shift_en ? CNT_W'(1) : '0;
    end else begin
      if (load) begin
        err_d = 1'b1;
      end
      if (shift_en) begin
        if (full) begin
          err_d = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
    end
    phase_d = phase_of(int'(count_d), TOTAL);
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      shadow_q <= '0;
      active_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      phase_q  <= PH_EMPTY;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      phase_q  <= phase_d;
    end
  end

  assign tail      = shadow_q[0];
  assign active    = active_q;
  assign cfg_valid = valid_q;
  assign cfg_full  = (phase_q == PH_FULL);
  assign cfg_err   = err_q;

endmodule

// File: rtl/logical_tile_io_bank_cfg.sv
// IO logical tile with NUM_PADS GPIO pads configured from one chain.
// Pad config only changes on a load, so streaming never glitches pads.
module logical_tile_io_bank_cfg
  import io_bank_cfg_pkg::*;
#(
  parameter int NUM_PADS = 4,
  parameter int CFG_BITS = 3
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic                ccff_shift_en,
  input  logic                ccff_head,
  input  logic                ccff_load,
  output logic                ccff_tail,
  inout  wire  [NUM_PADS-1:0] gfpga_pad_GPIO_PAD,
  input  logic [NUM_PADS-1:0] iopad_outpad,
  output logic [NUM_PADS-1:0] iopad_inpad,
  output logic                cfg_valid,
  output logic                cfg_full,
  output logic                cfg_err
);

  localparam int TOTAL = NUM_PADS * CFG_BITS;

  logic [TOTAL-1:0] active;

  io_bank_cfg_chain #(
    .TOTAL(TOTAL)
  ) u_chain (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .shift_en (ccff_shift_en),
    .head     (ccff_head),
    .load     (ccff_load),
    .tail     (ccff_tail),
    .active   (active),
    .cfg_valid(cfg_valid),
    .cfg_full (cfg_full),
    .cfg_err  (cfg_err)
  );

  for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
    logic dir;
    logic inv_in;
    logic inv_out;
    assign dir     = active[i*CFG_BITS + CFG_DIR];
    assign inv_in  = active[i*CFG_BITS + CFG_INV_IN];
    assign inv_out = active[i*CFG_BITS + CFG_INV_OUT];
    // Released pads read back whatever the board drives
    assign gfpga_pad_GPIO_PAD[i] = dir ? (iopad_outpad[i] ^ inv_out) : 1'bz;
    assign iopad_inpad[i] = gfpga_pad_GPIO_PAD[i] ^ inv_in;
  end

endmodule
